midi_event_decoder: RTL and testbench

MIDI_EVENT_DECODER -- requirements
Module: midi_event_decoder

---
 rtl/synth_pkg.sv | 39 +++
 rtl/midi_byte_parser.sv | 98 +++++++++
 rtl/midi_event_decoder.sv | 132 +++++++++++++
 tb/tb_midi_event_decoder.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the MIDI front end: event codes reported to
// the voice logic, the byte-parser state encoding, and the controller numbers
// and pitch-bend centre value that the decoder treats specially.
package synth_pkg;

    // Event codes. The first seven line up with the upper three bits of a
    // channel status byte (0x8n..0xEn), so the parser can use them directly.
    // ALL_OFF is a decoder-level reinterpretation of controller 123.
    typedef enum logic [2:0] {
        NOTE_OFF = 3'd0,
        NOTE_ON  = 3'd1,
        POLY_AT  = 3'd2,
        CTRL     = 3'd3,
        PRG_CH   = 3'd4,
        CH_AT    = 3'd5,
        PITCH    = 3'd6,
        ALL_OFF  = 3'd7
    } event_type_t;

    // IDLE: no running status. DATA1/DATA2: waiting for the first/second data
    // byte of the current running status. SYSEX: inside a system exclusive dump.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA1 = 2'd1,
        DATA2 = 2'd2,
        SYSEX = 2'd3
    } parse_state_t;

    localparam logic [13:0] PB_CENTER     = 14'h2000;
    localparam logic [6:0]  CC_ALL_OFF    = 7'd123;
    localparam logic [6:0]  CC_RESET_CTRL = 7'd121;

    // Program change and channel aftertouch carry a single data byte; every
    // other channel voice message carries two.
    function automatic logic is_one_data_byte(input event_type_t kind);
        return (kind == PRG_CH) || (kind == CH_AT);
    endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// MIDI byte-stream parser. Tracks running status through the stream of raw
// bytes and raises msg_done for exactly one cycle (combinationally, on the
// cycle the final data byte is presented) together with the message type,
// channel and data bytes. System realtime bytes pass through untouched so they
// may be interleaved anywhere, including between the data bytes of a message.
module midi_byte_parser
    import synth_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        reset_reg_N,
    input  logic        byteready,
    input  logic [7:0]  midi_in_data,
    output logic        msg_done,
    output event_type_t msg_type,
    output logic [3:0]  msg_channel,
    output logic [6:0]  msg_d1,
    output logic [6:0]  msg_d2
);

    parse_state_t state;
    parse_state_t next_state;
    event_type_t  rs_type;
    event_type_t  next_rs_type;
    logic [3:0]   rs_channel;
    logic [3:0]   next_rs_channel;
    logic [6:0]   d1_reg;
    logic [6:0]   next_d1;

    // Parser registers: state, the running status (type and channel) and the
    // first data byte of a two-byte message while the second is awaited.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state      <= IDLE;
            rs_type    <= NOTE_OFF;
            rs_channel <= 4'd0;
            d1_reg     <= 7'd0;
        end else begin
            state      <= next_state;
            rs_type    <= next_rs_type;
            rs_channel <= next_rs_channel;
            d1_reg     <= next_d1;
        end
    end

    // Byte classification, next state and completion strobe. Status bytes
    // always win over a partial message; realtime bytes (0xF8-0xFF) fall
    // through every branch and leave all parser state alone.
    always_comb begin
        next_state      = state;
        next_rs_type    = rs_type;
        next_rs_channel = rs_channel;
        next_d1         = d1_reg;
        msg_done        = 1'b0;
        msg_d1          = midi_in_data[6:0];
        msg_d2          = 7'd0;

        if (byteready) begin
            if (midi_in_data[7]) begin
                if (midi_in_data[7:4] != 4'hF) begin
                    next_state      = DATA1;
                    next_rs_type    = event_type_t'(midi_in_data[6:4]);
                    next_rs_channel = midi_in_data[3:0];
                end else if (!midi_in_data[3]) begin
                    next_rs_type    = NOTE_OFF;
                    next_rs_channel = 4'd0;
                    if (midi_in_data[2:0] == 3'd0) begin
                        next_state = SYSEX;
                    end else if ((state != SYSEX) || (midi_in_data[2:0] == 3'd7)) begin
                        next_state = IDLE;
                    end
                end
            end else begin
                case (state)
                    DATA1: begin
                        if (is_one_data_byte(rs_type)) begin
                            msg_done = 1'b1;
                        end else begin
                            next_d1    = midi_in_data[6:0];
                            next_state = DATA2;
                        end
                    end
                    DATA2: begin
                        msg_done   = 1'b1;
                        msg_d1     = d1_reg;
                        msg_d2     = midi_in_data[6:0];
                        next_state = DATA1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign msg_type    = rs_type;
    assign msg_channel = rs_channel;

endmodule

// File: rtl/midi_event_decoder.sv
// MIDI channel-event decoder for a multitimbral synth. The byte parser turns
// the raw stream into complete messages; this level decides which parts a
// message addresses, folds the special cases (velocity-0 note-on, all-notes-off
// controller) into the event code, holds one event for a valid/ready consumer,
// and keeps the per-part pitch-bend registers current.
module midi_event_decoder
    import synth_pkg::*;
#(
    parameter int NUM_PARTS = 4,
    parameter int P_WIDTH   = 2
)
(
    input  logic                      CLOCK_50,
    input  logic                      reset_reg_N,
    input  logic                      byteready,
    input  logic [7:0]                midi_in_data,
    input  logic [4*NUM_PARTS-1:0]    part_ch,
    input  logic                      omni,
    input  logic                      event_ready,
    output logic                      event_valid,
    output event_type_t               event_type,
    output logic [NUM_PARTS-1:0]      event_mask,
    output logic [6:0]                event_d1,
    output logic [6:0]                event_d2,
    output logic [14*NUM_PARTS-1:0]   pitch_bend,
    output logic                      overflow
);

    // Parts whose index fits in P_WIDTH bits; with a consistent
    // parameterisation this is simply NUM_PARTS.
    localparam int ADDRESSABLE_PARTS =
        ((1 << P_WIDTH) < NUM_PARTS) ? (1 << P_WIDTH) : NUM_PARTS;

    logic                 msg_done;
    event_type_t          msg_type;
    logic [3:0]           msg_channel;
    logic [6:0]           msg_d1;
    logic [6:0]           msg_d2;
    logic [NUM_PARTS-1:0] part_match;
    event_type_t          final_type;
    logic                 emit;
    logic                 accept;
    logic                 bend_load;
    logic                 bend_center;

    midi_byte_parser u_parser (
        .CLOCK_50     (CLOCK_50),
        .reset_reg_N  (reset_reg_N),
        .byteready    (byteready),
        .midi_in_data (midi_in_data),
        .msg_done     (msg_done),
        .msg_type     (msg_type),
        .msg_channel  (msg_channel),
        .msg_d1       (msg_d1),
        .msg_d2       (msg_d2)
    );

    // A part responds when omni is on or its channel setting equals the
    // channel of the message being completed.
    always_comb begin
        part_match = '0;
        for (int p = 0; p < ADDRESSABLE_PARTS; p++) begin
            if (omni || (part_ch[4*p +: 4] == msg_channel)) begin
                part_match[p] = 1'b1;
            end
        end
    end

    // Reported event code: a note-on with zero velocity is really a note-off,
    // and controller 123 is surfaced as its own all-notes-off event.
    always_comb begin
        final_type = msg_type;
        if ((msg_type == NOTE_ON) && (msg_d2 == 7'd0)) begin
            final_type = NOTE_OFF;
        end else if ((msg_type == CTRL) && (msg_d1 == CC_ALL_OFF)) begin
            final_type = ALL_OFF;
        end
    end

    assign emit        = msg_done && (part_match != '0);
    assign accept      = event_valid && event_ready;
    assign bend_load   = msg_done && (msg_type == PITCH);
    assign bend_center = msg_done && (msg_type == CTRL) && (msg_d1 == CC_RESET_CTRL);

    // Single-entry event holding register with valid/ready handshake. A new
    // event may replace the held one only in the cycle it is being accepted;
    // otherwise the newcomer is dropped and the sticky overflow flag records it.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            event_valid <= 1'b0;
            event_type  <= NOTE_OFF;
            event_mask  <= '0;
            event_d1    <= 7'd0;
            event_d2    <= 7'd0;
            overflow    <= 1'b0;
        end else begin
            if (emit && (!event_valid || accept)) begin
                event_valid <= 1'b1;
                event_type  <= final_type;
                event_mask  <= part_match;
                event_d1    <= msg_d1;
                event_d2    <= msg_d2;
            end else if (accept) begin
                event_valid <= 1'b0;
            end
            if (emit && event_valid && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    // Per-part pitch-bend registers. They track the stream directly, so a bend
    // or reset-controllers message takes effect even if its event is dropped.
    always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                pitch_bend[14*p +: 14] <= PB_CENTER;
            end
        end else begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                if (part_match[p]) begin
                    if (bend_load) begin
                        pitch_bend[14*p +: 14] <= {msg_d2, msg_d1};
                    end else if (bend_center) begin
                        pitch_bend[14*p +: 14] <= PB_CENTER;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_event_decoder.sv
// Testbench for midi_event_decoder: directed scenarios for the headline
// behaviours followed by a long randomized byte stream, all compared against a
// message-level reference model that collects data bytes into a queue.
module tb_midi_event_decoder;
    import synth_pkg::*;

    localparam int NUM_PARTS = 4;
    localparam int P_WIDTH   = 2;

    logic                    CLOCK_50 = 1'b0;
    logic                    reset_reg_N;
    logic                    byteready;
    logic [7:0]              midi_in_data;
    logic [4*NUM_PARTS-1:0]  part_ch;
    logic                    omni;
    logic                    event_ready;
    logic                    event_valid;
    event_type_t             event_type;
    logic [NUM_PARTS-1:0]    event_mask;
    logic [6:0]              event_d1;
    logic [6:0]              event_d2;
    logic [14*NUM_PARTS-1:0] pitch_bend;
    logic                    overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit                   m_have_status;
    bit                   m_sysex;
    logic [7:0]           m_status;
    logic [6:0]           m_buf[$];
    bit                   m_valid;
    event_type_t          m_type;
    logic [NUM_PARTS-1:0] m_mask;
    logic [6:0]           m_d1;
    logic [6:0]           m_d2;
    bit                   m_ovf;
    logic [13:0]          m_pb[NUM_PARTS];

    midi_event_decoder #(.NUM_PARTS(NUM_PARTS), .P_WIDTH(P_WIDTH)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_reg_N  (reset_reg_N),
        .byteready    (byteready),
        .midi_in_data (midi_in_data),
        .part_ch      (part_ch),
        .omni         (omni),
        .event_ready  (event_ready),
        .event_valid  (event_valid),
        .event_type   (event_type),
        .event_mask   (event_mask),
        .event_d1     (event_d1),
        .event_d2     (event_d2),
        .pitch_bend   (pitch_bend),
        .overflow     (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic model_reset();
        m_have_status = 0;
        m_sysex       = 0;
        m_status      = 8'h00;
        m_buf.delete();
        m_valid       = 0;
        m_type        = NOTE_OFF;
        m_mask        = '0;
        m_d1          = 7'd0;
        m_d2          = 7'd0;
        m_ovf         = 0;
        for (int p = 0; p < NUM_PARTS; p++) m_pb[p] = 14'h2000;
    endtask

    // Message-level parse: collect data bytes under the current status until
    // the message length for that status is reached.
    task automatic model_byte(input logic [7:0] b, output bit done, output logic [7:0] st,
                              output logic [6:0] d1, output logic [6:0] d2);
        int need;
        done = 0;
        st   = m_status;
        d1   = 7'd0;
        d2   = 7'd0;
        if (b >= 8'hF8) return;
        if (b >= 8'h80 && b <= 8'hEF) begin
            m_status = b; m_have_status = 1; m_sysex = 0; m_buf.delete();
        end else if (b == 8'hF0) begin
            m_have_status = 0; m_sysex = 1; m_buf.delete();
        end else if (b >= 8'hF1) begin
            if (!m_sysex || b == 8'hF7) begin
                m_sysex = 0; m_have_status = 0; m_buf.delete();
            end
        end else if (m_have_status) begin
            m_buf.push_back(b[6:0]);
            need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
            if (m_buf.size() == need) begin
                done = 1;
                st   = m_status;
                d1   = m_buf[0];
                if (need == 2) d2 = m_buf[1];
                m_buf.delete();
            end
        end
    endtask

    // One clock of the model: parse, address parts, update bends, handshake.
    task automatic model_cycle(input bit br, input logic [7:0] b, input bit rdy);
        bit done, accept, emit;
        logic [7:0] st;
        logic [6:0] d1, d2;
        logic [NUM_PARTS-1:0] mask;
        event_type_t kind;
        done = 0; st = 8'h00; d1 = 7'd0; d2 = 7'd0;
        if (br) model_byte(b, done, st, d1, d2);
        mask = '0;
        for (int p = 0; p < NUM_PARTS; p++)
            if (omni || part_ch[4*p +: 4] == st[3:0]) mask[p] = 1'b1;
        case (st[7:4])
            4'h8:    kind = NOTE_OFF;
            4'h9:    kind = NOTE_ON;
            4'hA:    kind = POLY_AT;
            4'hB:    kind = CTRL;
            4'hC:    kind = PRG_CH;
            4'hD:    kind = CH_AT;
            default: kind = PITCH;
        endcase
        if (done) begin
            for (int p = 0; p < NUM_PARTS; p++) begin
                if (mask[p] && st[7:4] == 4'hE) m_pb[p] = {d2, d1};
                if (mask[p] && st[7:4] == 4'hB && d1 == 7'd121) m_pb[p] = 14'h2000;
            end
        end
        if (kind == NOTE_ON && d2 == 7'd0) kind = NOTE_OFF;
        if (kind == CTRL && d1 == 7'd123) kind = ALL_OFF;
        accept = m_valid && rdy;
        emit   = done && (mask != '0);
        if (emit && m_valid && !accept) begin
            m_ovf = 1;
        end else if (emit) begin
            m_valid = 1; m_type = kind; m_mask = mask; m_d1 = d1; m_d2 = d2;
        end else if (accept) begin
            m_valid = 0;
        end
    endtask

    // Drive one clock cycle of inputs from a negedge, advance the model at the
    // posedge, and return on the next negedge ready for sampling.
    task automatic applyStimulus(input bit br, input logic [7:0] b, input bit rdy);
        byteready    = br;
        midi_in_data = b;
        event_ready  = rdy;
        @(posedge CLOCK_50);
        model_cycle(br, b, rdy);
        @(negedge CLOCK_50);
        byteready = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit rdy);
        applyStimulus(1'b1, b, rdy);
    endtask

    task automatic pulse_reset();
        #2 reset_reg_N = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge CLOCK_50);
        reset_reg_N = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", event_valid); end
        checks++; if (event_type !== NOTE_OFF) begin errors++; $display("[TB] FAIL reset_type: got %0d expected 0", event_type); end
        checks++; if (event_mask !== 4'b0000) begin errors++; $display("[TB] FAIL reset_mask: got %b expected 0000", event_mask); end
        checks++; if (event_d1 !== 7'd0 || event_d2 !== 7'd0) begin errors++; $display("[TB] FAIL reset_data: got %h/%h expected 00/00", event_d1, event_d2); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++; if (pitch_bend !== {4{14'h2000}}) begin errors++; $display("[TB] FAIL reset_bend: got %h expected all 2000", pitch_bend); end
        release_reset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checks++; if (event_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: got valid %0b ovf %0b expected 0 0", event_valid, overflow); end
    endtask

    task automatic test_note_on();
        part_ch = {4'd3, 4'd2, 4'd1, 4'd0};
        omni    = 1'b0;
        send(8'h91, 1'b1);
        send(8'h3C, 1'b1);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL note_on_early: got %0b expected 0", event_valid); end
        send(8'h64, 1'b1);
        checks++; if (event_valid !== 1'b1) begin errors++; $display("[TB] FAIL note_on_valid: got %0b expected 1", event_valid); end
        checks++; if (event_type !== NOTE_ON) begin errors++; $display("[TB] FAIL note_on_type: got %0d expected %0d", event_type, NOTE_ON); end
        checks++; if (event_mask !== 4'b0010) begin errors++; $display("[TB] FAIL note_on_mask: got %b expected 0010", event_mask); end
        checks++; if (event_d1 !== 7'h3C || event_d2 !== 7'h64) begin errors++; $display("[TB] FAIL note_on_data: got %h/%h expected 3c/64", event_d1, event_d2); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL note_on_accepted: got %0b expected 0", event_valid); end
    endtask

    task automatic test_running_status();
        send(8'h90, 1'b1);
        send(8'h40, 1'b1);
        send(8'h7F, 1'b1);
        checks++; if (event_valid !== 1'b1 || event_type !== NOTE_ON || event_d2 !== 7'h7F) begin errors++; $display("[TB] FAIL rs_first: got v%0b t%0d d2 %h expected v1 t1 d2 7f", event_valid, event_type, event_d2); end
        send(8'h40, 1'b1);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL rs_between: got %0b expected 0", event_valid); end
        send(8'h00, 1'b1);
        checks++; if (event_valid !== 1'b1 || event_type !== NOTE_OFF) begin errors++; $display("[TB] FAIL rs_note_off: got v%0b t%0d expected v1 t0", event_valid, event_type); end
        checks++; if (event_d1 !== 7'h40 || event_d2 !== 7'h00) begin errors++; $display("[TB] FAIL rs_data: got %h/%h expected 40/00", event_d1, event_d2); end
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_pitch();
        send(8'hE0, 1'b1);
        send(8'hF8, 1'b1);
        send(8'h00, 1'b1);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL pitch_early: got %0b expected 0", event_valid); end
        send(8'h40, 1'b1);
        checks++; if (event_valid !== 1'b1 || event_type !== PITCH) begin errors++; $display("[TB] FAIL pitch_event: got v%0b t%0d expected v1 t6", event_valid, event_type); end
        checks++; if (pitch_bend[13:0] !== 14'h2000) begin errors++; $display("[TB] FAIL pitch_center: got %h expected 2000", pitch_bend[13:0]); end
        send(8'hE0, 1'b1);
        send(8'h7F, 1'b1);
        send(8'h7F, 1'b1);
        checks++; if (pitch_bend[13:0] !== 14'h3FFF) begin errors++; $display("[TB] FAIL pitch_max: got %h expected 3fff", pitch_bend[13:0]); end
        checks++; if (pitch_bend[27:14] !== 14'h2000) begin errors++; $display("[TB] FAIL pitch_other_part: got %h expected 2000", pitch_bend[27:14]); end
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_sysex();
        logic [7:0] seq[6];
        seq = '{8'hF0, 8'h43, 8'h10, 8'hF7, 8'h3C, 8'h40};
        foreach (seq[i]) begin
            send(seq[i], 1'b1);
            checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL sysex_no_event: byte %0d got %0b expected 0", i, event_valid); end
        end
        checks++; if (pitch_bend[13:0] !== 14'h3FFF) begin errors++; $display("[TB] FAIL sysex_bend_kept: got %h expected 3fff", pitch_bend[13:0]); end
    endtask

    task automatic test_controllers();
        omni = 1'b1;
        send(8'hE5, 1'b1); send(8'h00, 1'b1); send(8'h00, 1'b1);
        checks++; if (pitch_bend !== 56'h0 || event_mask !== 4'b1111) begin errors++; $display("[TB] FAIL omni_bend: got %h mask %b expected 0 1111", pitch_bend, event_mask); end
        send(8'hB5, 1'b1); send(8'h79, 1'b1); send(8'h00, 1'b1);
        checks++; if (event_type !== CTRL || event_d1 !== 7'd121) begin errors++; $display("[TB] FAIL reset_ctrl_event: got t%0d d1 %0d expected t3 d1 121", event_type, event_d1); end
        checks++; if (pitch_bend !== {4{14'h2000}}) begin errors++; $display("[TB] FAIL reset_ctrl_bend: got %h expected all 2000", pitch_bend); end
        send(8'h7B, 1'b1); send(8'h00, 1'b1);
        checks++; if (event_valid !== 1'b1 || event_type !== ALL_OFF) begin errors++; $display("[TB] FAIL all_off: got v%0b t%0d expected v1 t7", event_valid, event_type); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        omni = 1'b0;
    endtask

    task automatic test_overflow();
        send(8'hC2, 1'b0);
        send(8'h05, 1'b0);
        checks++; if (event_valid !== 1'b1 || event_type !== PRG_CH || event_mask !== 4'b0100) begin errors++; $display("[TB] FAIL prg_event: got v%0b t%0d m%b expected v1 t4 m0100", event_valid, event_type, event_mask); end
        send(8'hC2, 1'b0);
        send(8'h06, 1'b0);
        checks++; if (event_valid !== 1'b1 || event_d1 !== 7'h05) begin errors++; $display("[TB] FAIL ovf_hold: got v%0b d1 %h expected v1 05", event_valid, event_d1); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_accept: got %0b expected 0", event_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_reset_mid();
        send(8'h93, 1'b1);
        pulse_reset();
        checks++; if (event_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got v%0b o%0b expected 0 0", event_valid, overflow); end
        checks++; if (event_d1 !== 7'd0 || event_mask !== 4'b0 || event_type !== NOTE_OFF) begin errors++; $display("[TB] FAIL midreset_fields: got d1 %h m %b t %0d expected 0", event_d1, event_mask, event_type); end
        release_reset();
        send(8'h3C, 1'b1);
        send(8'h10, 1'b1);
        checks++; if (event_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_event: got %0b expected 0", event_valid); end
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        logic [6:0] specials[4];
        specials = '{7'd121, 7'd123, 7'd0, 7'd64};
        r = $urandom_range(99);
        if (r < 25) return {1'b1, 3'($urandom_range(6)), 4'($urandom_range(4))};
        if (r < 30) return 8'(8'hF0 + $urandom_range(7));
        if (r < 35) return 8'(8'hF8 + $urandom_range(7));
        if (r < 45) return {1'b0, specials[$urandom_range(3)]};
        return 8'($urandom_range(127));
    endfunction

    task automatic test_random();
        for (int step = 0; step < 2000; step++) begin
            if (step % 400 == 0) begin
                for (int p = 0; p < NUM_PARTS; p++) part_ch[4*p +: 4] = 4'($urandom_range(3));
                omni = ($urandom_range(3) == 0);
            end
            applyStimulus($urandom_range(99) < 60, rand_byte(), $urandom_range(99) < 70);
            checks++; if (event_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid: step %0d got %0b expected %0b", step, event_valid, m_valid); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("[TB] FAIL rand_overflow: step %0d got %0b expected %0b", step, overflow, m_ovf); end
            for (int p = 0; p < NUM_PARTS; p++) begin
                checks++; if (pitch_bend[14*p +: 14] !== m_pb[p]) begin errors++; $display("[TB] FAIL rand_bend: step %0d part %0d got %h expected %h", step, p, pitch_bend[14*p +: 14], m_pb[p]); end
            end
            if (m_valid) begin
                checks++;
                if (event_type !== m_type || event_mask !== m_mask || event_d1 !== m_d1 || event_d2 !== m_d2) begin
                    errors++;
                    $display("[TB] FAIL rand_event: step %0d got t%0d m%b %h/%h expected t%0d m%b %h/%h",
                             step, event_type, event_mask, event_d1, event_d2, m_type, m_mask, m_d1, m_d2);
                end
            end
        end
    endtask

    initial begin
        reset_reg_N  = 1'b0;
        byteready    = 1'b0;
        midi_in_data = 8'h00;
        part_ch      = '0;
        omni         = 1'b0;
        event_ready  = 1'b0;
        model_reset();
        @(negedge CLOCK_50);
        test_reset();
        test_note_on();
        test_running_status();
        test_pitch();
        test_sysex();
        test_controllers();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
